// File: rtl/audio_dac_tx.sv
// audio_dac_tx: stereo serializer driving the codec DAC data pin.
// Define DAC_TX_I2S_DELAY_EN for I2S framing (one-bit delay, lrck low = left).
module audio_dac_tx #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             state_clk,
   input  logic             reset,
   input  logic             aud_bclk,
   input  logic             aud_lrck,
   input  logic [WIDTH-1:0] left_in,
   input  logic [WIDTH-1:0] right_in,
   input  logic             in_valid,
   input  logic             underrun_clr,
   output logic             aud_dacdat,
   output logic             sample_req,
   output logic             underrun
);

`ifdef DAC_TX_I2S_DELAY_EN
   localparam logic I2S = 1'b1;
`else
   localparam logic I2S = 1'b0;
`endif
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      WAIT_SYNC,
      SHIFT,
      PAD
   } state_t;

   logic [SYNC_STAGES-1:0] bclk_sync_q;
   logic [SYNC_STAGES-1:0] lrck_sync_q;
   logic                   bclk_hist_q;
   logic                   lrck_cap_q;
   logic                   primed_q;
   logic                   bclk_s;
   logic                   lrck_s;
   logic                   bclk_fall;
   logic                   slot_start;
   logic                   left_start;

   logic [WIDTH-1:0] pend_l_q, pend_l_d;
   logic [WIDTH-1:0] pend_r_q, pend_r_d;
   logic [WIDTH-1:0] act_l_q, act_l_d;
   logic [WIDTH-1:0] act_r_q, act_r_d;
   logic             pending_q, pending_d;
   logic             underrun_q, underrun_d;
   logic             req_q;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    bitcnt_q, bitcnt_d;
   logic             dly_q, dly_d;
   logic             dac_q, dac_d;
   logic [WIDTH-1:0] load_val;

   assign bclk_s     = bclk_sync_q[SYNC_STAGES-1];
   assign lrck_s     = lrck_sync_q[SYNC_STAGES-1];
   assign bclk_fall  = !bclk_s && bclk_hist_q;
   assign slot_start = bclk_fall && primed_q && (lrck_s != lrck_cap_q);
   assign left_start = slot_start && (lrck_s ^ I2S);

   assign aud_dacdat = dac_q;
   assign sample_req = req_q;
   assign underrun   = underrun_q;

   // Synchronize the codec clocks and capture lrck on each bclk fall.
   always_ff @(posedge state_clk) begin
      if (reset) begin
         bclk_sync_q <= '0;
         lrck_sync_q <= '0;
         bclk_hist_q <= 1'b0;
         lrck_cap_q  <= 1'b0;
         primed_q    <= 1'b0;
      end else begin
         bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], aud_bclk};
         lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], aud_lrck};
         bclk_hist_q <= bclk_s;
         if (bclk_fall) begin
            lrck_cap_q <= lrck_s;
            primed_q   <= 1'b1;
         end
      end
   end

   // Pending/active sample pair handoff and underrun detection.
   always_comb begin
      pend_l_d   = pend_l_q;
      pend_r_d   = pend_r_q;
      act_l_d    = act_l_q;
      act_r_d    = act_r_q;
      pending_d  = pending_q;
      underrun_d = underrun_q & ~underrun_clr;
      if (left_start) begin
         if (in_valid) begin
            act_l_d   = left_in;
            act_r_d   = right_in;
            pending_d = 1'b0;
         end else if (pending_q) begin
            act_l_d   = pend_l_q;
            act_r_d   = pend_r_q;
            pending_d = 1'b0;
         end else begin
            underrun_d = 1'b1;
         end
      end else if (in_valid) begin
         pend_l_d  = left_in;
         pend_r_d  = right_in;
         pending_d = 1'b1;
      end
   end

   // Sample registers, sticky underrun and the frame strobe.
   always_ff @(posedge state_clk) begin
      if (reset) begin
         pend_l_q   <= '0;
         pend_r_q   <= '0;
         act_l_q    <= '0;
         act_r_q    <= '0;
         pending_q  <= 1'b0;
         underrun_q <= 1'b0;
         req_q      <= 1'b0;
      end else begin
         pend_l_q   <= pend_l_d;
         pend_r_q   <= pend_r_d;
         act_l_q    <= act_l_d;
         act_r_q    <= act_r_d;
         pending_q  <= pending_d;
         underrun_q <= underrun_d;
         req_q      <= left_start;
      end
   end

   assign load_val = (lrck_s ^ I2S) ? act_l_d : act_r_d;

   // Slot state machine: next state, shifter and serial output.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      dly_d    = dly_q;
      dac_d    = dac_q;
      if (slot_start) begin
         state_d  = SHIFT;
         shreg_d  = load_val;
         bitcnt_d = CW'(WIDTH - 1);
         dly_d    = I2S;
         dac_d    = I2S ? 1'b0 : load_val[WIDTH-1];
      end else if (bclk_fall) begin
         unique case (state_q)
            WAIT_SYNC: dac_d = 1'b0;
            SHIFT: begin
               if (dly_q) begin
                  dly_d = 1'b0;
                  dac_d = shreg_q[WIDTH-1];
               end else if (bitcnt_q == '0) begin
                  state_d = PAD;
                  dac_d   = 1'b0;
               end else begin
                  shreg_d  = shreg_q << 1;
                  bitcnt_d = bitcnt_q - 1'b1;
                  dac_d    = shreg_q[WIDTH-2];
               end
            end
            PAD:     dac_d = 1'b0;
            default: begin
               state_d = WAIT_SYNC;
               dac_d   = 1'b0;
            end
         endcase
      end
   end

   // State register and registered DAC output.
   always_ff @(posedge state_clk) begin
      if (reset) begin
         state_q  <= WAIT_SYNC;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         dly_q    <= 1'b0;
         dac_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         dly_q    <= dly_d;
         dac_q    <= dac_d;
      end
   end

endmodule

// File: tb/tb_audio_dac_tx.sv
// tb_audio_dac_tx: directed bench for audio_dac_tx.
// Codec model: bclk = state_clk/8, 32 bclk per slot, left slot first.
module tb_audio_dac_tx;

`ifdef DAC_TX_I2S_DELAY_EN
   localparam logic I2S = 1'b1;
`else
   localparam logic I2S = 1'b0;
`endif

   logic        state_clk = 1'b0;
   logic        reset;
   logic        aud_bclk;
   logic        aud_lrck;
   logic [15:0] left_in;
   logic [15:0] right_in;
   logic        in_valid;
   logic        underrun_clr;
   logic        aud_dacdat;
   logic        sample_req;
   logic        underrun;

   int          errors = 0;
   int          checks = 0;
   int          bpos;
   int          frames = 0;
   logic [63:0] fbits = '0;
   logic [63:0] last_frame = '0;
   int          req_hi = 0;
   int          req_pulses = 0;
   logic        req_prev = 1'b0;
   int          f0;
   int          p0;
   int          bad;
   bit          ok;

   audio_dac_tx dut (
      .state_clk    (state_clk),
      .reset        (reset),
      .aud_bclk     (aud_bclk),
      .aud_lrck     (aud_lrck),
      .left_in      (left_in),
      .right_in     (right_in),
      .in_valid     (in_valid),
      .underrun_clr (underrun_clr),
      .aud_dacdat   (aud_dacdat),
      .sample_req   (sample_req),
      .underrun     (underrun)
   );

   always #10 state_clk = ~state_clk;

   function automatic logic [31:0] slot(input logic [15:0] x);
      if (I2S) return {1'b0, x, 15'b0};
      return {x, 16'b0};
   endfunction

   function automatic logic [63:0] frm(input logic [15:0] l,
                                       input logic [15:0] r);
      return {slot(l), slot(r)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] l, input logic [15:0] r);
      left_in  = l;
      right_in = r;
      in_valid = 1'b1;
      @(negedge state_clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_req(output bit k);
      k = 1'b0;
      for (int i = 0; i < 800; i++) begin
         @(negedge state_clk);
         if (sample_req) begin
            k = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_frame(input int f, output bit k);
      k = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge state_clk);
         if (frames != f) begin
            k = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_bpos(input int p, output bit k);
      k = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge aud_bclk);
         if (bpos == p) begin
            k = 1'b1;
            break;
         end
      end
   endtask

   // Codec: lrck moves with bclk fall; DAC data captured on bclk rise.
   initial begin
      aud_bclk = 1'b1;
      bpos     = 63;
      aud_lrck = I2S;
      #3;
      forever begin
         #80;
         bpos     = (bpos == 63) ? 0 : bpos + 1;
         aud_lrck = (bpos < 32) ? !I2S : I2S;
         aud_bclk = 1'b0;
         #80;
         aud_bclk = 1'b1;
         fbits[63-bpos] = aud_dacdat;
         if (bpos == 63) begin
            last_frame = fbits;
            frames++;
         end
      end
   end

   always @(negedge state_clk) begin
      if (sample_req) req_hi++;
      if (sample_req && !req_prev) req_pulses++;
      req_prev = sample_req;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      in_valid     = 1'b0;
      underrun_clr = 1'b0;
      left_in      = '0;
      right_in     = '0;
      repeat (3) @(negedge state_clk);
      chk("rst_dac", 64'(aud_dacdat), 64'(0));
      chk("rst_req", 64'(sample_req), 64'(0));
      chk("rst_urun", 64'(underrun), 64'(0));
      reset = 1'b0;
      @(negedge state_clk);
      send(16'hA5C3, 16'h0F0F);

      for (int i = 0; i < 4; i++) begin
         wait_req(ok);
         chk("req_wait", 64'(ok), 64'(1));
         f0 = frames;
         repeat (5) @(negedge state_clk);
         send(16'hA5C3, 16'h0F0F);
         wait_frame(f0, ok);
         chk("frame_wait", 64'(ok), 64'(1));
         chk("frame_a5c3", last_frame, frm(16'hA5C3, 16'h0F0F));
      end
      chk("req_pulses", 64'(req_pulses), 64'(4));
      chk("req_width", 64'(req_hi), 64'(4));
      chk("no_urun", 64'(underrun), 64'(0));

      wait_req(ok);
      f0 = frames;
      wait_frame(f0, ok);
      wait_req(ok);
      chk("urun_req", 64'(ok), 64'(1));
      chk("urun_set", 64'(underrun), 64'(1));
      f0 = frames;
      underrun_clr = 1'b1;
      @(negedge state_clk);
      underrun_clr = 1'b0;
      chk("urun_clr", 64'(underrun), 64'(0));
      wait_frame(f0, ok);
      chk("repeat_frame", last_frame, frm(16'hA5C3, 16'h0F0F));

      wait_bpos(0, ok);
      chk("byp_bpos", 64'(ok), 64'(1));
      repeat (2) @(negedge state_clk);
      f0 = frames;
      send(16'h8001, 16'h7FFE);
      chk("byp_req", 64'(sample_req), 64'(1));
      chk("byp_urun", 64'(underrun), 64'(0));
      wait_frame(f0, ok);
      chk("byp_frame", last_frame, frm(16'h8001, 16'h7FFE));
      wait_req(ok);
      chk("byp_pend0", 64'(underrun), 64'(1));
      f0 = frames;
      underrun_clr = 1'b1;
      send(16'hA5C3, 16'h0F0F);
      underrun_clr = 1'b0;
      wait_frame(f0, ok);
      chk("byp_repeat", last_frame, frm(16'h8001, 16'h7FFE));

      wait_bpos(8, ok);
      chk("rst_bpos", 64'(ok), 64'(1));
      repeat (3) @(negedge state_clk);
      chk("pre_rst_dac", 64'(aud_dacdat), 64'(1));
      reset = 1'b1;
      @(negedge state_clk);
      reset = 1'b0;
      chk("mid_rst_dac", 64'(aud_dacdat), 64'(0));
      chk("mid_rst_req", 64'(sample_req), 64'(0));
      chk("mid_rst_urun", 64'(underrun), 64'(0));
      p0  = req_pulses;
      bad = 0;
      for (int i = 0; i < 600 && bpos != 32; i++) begin
         @(negedge state_clk);
         if (aud_dacdat !== 1'b0) bad++;
      end
      chk("quiet_to", 64'(bpos), 64'(32));
      chk("quiet_dac", 64'(bad), 64'(0));
      chk("quiet_req", 64'(req_pulses), 64'(p0));
      send(16'hA5C3, 16'h0F0F);
      wait_req(ok);
      chk("recov_req", 64'(ok), 64'(1));
      chk("recov_urun", 64'(underrun), 64'(0));
      f0 = frames;
      wait_frame(f0, ok);
      chk("recov_frame", last_frame, frm(16'hA5C3, 16'h0F0F));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
